// File: rtl/bit_ser_pkg.sv
// Shared definitions for the bit-serial adder controller.
//   state_e       : controller FSM state encoding
//   DEFAULT_WIDTH : default operand/result width
//   maj3          : full-adder carry (majority of three)
package bit_ser_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/bit_ser_add_ctrl_if.sv
// Host-side bus of the bit-serial adder controller.
//   start/sub/a_in/b_in : request and operands (host -> controller)
//   busy/done/sum/cout  : status and registered result (controller -> host)
//   serial_result       : sum bit being produced this cycle
// Modports: master = host, slave = controller.
interface bit_ser_add_ctrl_if
  import bit_ser_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             serial_result;

  modport master (
    output start, sub, a_in, b_in,
    input  busy, done, sum, cout, serial_result
  );

  modport slave (
    input  start, sub, a_in, b_in,
    output busy, done, sum, cout, serial_result
  );

endinterface

// File: rtl/bit_serial_fa.sv
// Single full-adder cell with a carry flop.
//   clk, clr_n : clock, async active-low clear of the carry
//   load       : synchronous load of load_val into the carry (has priority)
//   en         : advance the carry to this bit's carry-out
//   a, b       : operand bits
//   s          : combinational sum bit
//   carry_q    : registered carry
module bit_serial_fa
  import bit_ser_pkg::*;
(
  input  logic clk,
  input  logic clr_n,
  input  logic load,
  input  logic load_val,
  input  logic en,
  input  logic a,
  input  logic b,
  output logic s,
  output logic carry_q
);

  assign s = a ^ b ^ carry_q;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      carry_q <= 1'b0;
    end else if (load) begin
      carry_q <= load_val;
    end else if (en) begin
      carry_q <= maj3(a, b, carry_q);
    end
  end

endmodule

// File: rtl/bit_ser_add_ctrl.sv
// Bit-serial add/subtract controller. Captures two parallel operands on start,
// feeds them LSB-first through one full-adder cell, reassembles the sum and
// pulses done for one cycle.
//   clk, clr_n : clock, async active-low reset
//   bus        : host bus (slave side), see bit_ser_add_ctrl_if
// Subtraction is A + ~B + 1: B is inverted at capture and the carry preset to 1.
module bit_ser_add_ctrl
  import bit_ser_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                clk,
  input  logic                clr_n,
  bit_ser_add_ctrl_if.slave   bus
);

  localparam int unsigned     CntW    = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e            state_q;
  logic [WIDTH-1:0]  sh_a_q;
  logic [WIDTH-1:0]  sh_b_q;
  logic [WIDTH-1:0]  sum_sh_q;
  logic [WIDTH-1:0]  sum_q;
  logic [CntW-1:0]   cnt_q;
  logic              busy_q;
  logic              done_q;
  logic              cout_q;

  logic              fa_load;
  logic              fa_en;
  logic              fa_s;
  logic              carry_q;

  assign fa_load = (state_q == ST_IDLE) && bus.start;
  assign fa_en   = (state_q == ST_SHIFT);

  bit_serial_fa u_fa (
    .clk      (clk),
    .clr_n    (clr_n),
    .load     (fa_load),
    .load_val (bus.sub),
    .en       (fa_en),
    .a        (sh_a_q[0]),
    .b        (sh_b_q[0]),
    .s        (fa_s),
    .carry_q  (carry_q)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q  <= ST_IDLE;
      sh_a_q   <= '0;
      sh_b_q   <= '0;
      sum_sh_q <= '0;
      sum_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cout_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            sh_a_q  <= bus.a_in;
            sh_b_q  <= bus.sub ? ~bus.b_in : bus.b_in;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          sh_a_q   <= {1'b0, sh_a_q[WIDTH-1:1]};
          sh_b_q   <= {1'b0, sh_b_q[WIDTH-1:1]};
          sum_sh_q <= {fa_s, sum_sh_q[WIDTH-1:1]};
          cnt_q    <= cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
            // Final bit: publish the word including this cycle's sum bit.
            sum_q   <= {fa_s, sum_sh_q[WIDTH-1:1]};
            cout_q  <= maj3(sh_a_q[0], sh_b_q[0], carry_q);
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.sum           = sum_q;
  assign bus.cout          = cout_q;
  assign bus.serial_result = (state_q == ST_SHIFT) & fa_s;

endmodule

// File: tb/tb_bit_ser_add_ctrl.sv
// Directed self-checking bench for bit_ser_add_ctrl (WIDTH = 8).
module tb_bit_ser_add_ctrl;

  logic clk;
  logic clr_n;
  int   total;
  int   bad;

  bit_ser_add_ctrl_if #(.WIDTH(8)) bus ();

  bit_ser_add_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Launches one operation and checks latency, serial stream, result and pulse width.
  // poke: re-pulse start with other operands during SHIFT and again in DONE.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                       input logic [7:0] es, input logic ec, input bit poke);
    int         cyc;
    int         extra;
    logic [7:0] ser;
    @(negedge clk);
    bus.a_in  = a;
    bus.b_in  = b;
    bus.sub   = s;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check_val("busy_rise", bus.busy, 1);
    ser = '0;
    cyc = 1;
    while (!bus.done && cyc < 40) begin
      if (cyc <= 8) ser[3'(cyc - 1)] = bus.serial_result;
      if (poke && cyc == 3) begin
        bus.start = 1'b1;
        bus.a_in  = 8'hff;
        bus.b_in  = 8'hff;
        bus.sub   = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    check_val("latency", cyc, 9);
    check_val("sum", bus.sum, es);
    check_val("cout", bus.cout, ec);
    check_val("serial", ser, es);
    check_val("ser_in_done", bus.serial_result, 0);
    if (poke) bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check_val("done_width", bus.done, 0);
    check_val("busy_fall", bus.busy, 0);
    if (poke) begin
      extra = 0;
      repeat (12) begin
        @(negedge clk);
        if (bus.done || bus.busy) extra++;
      end
      check_val("ignored_start", extra, 0);
      check_val("sum_hold", bus.sum, es);
    end
  endtask

  initial begin
    int   ndone;
    int   last;
    logic prev_d;
    logic [7:0] exp;
    total     = 0;
    bad       = 0;
    clr_n     = 1'b0;
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.a_in  = '0;
    bus.b_in  = '0;
    #12;
    check_val("rst_busy", bus.busy, 0);
    check_val("rst_done", bus.done, 0);
    check_val("rst_sum", bus.sum, 0);
    check_val("rst_cout", bus.cout, 0);
    check_val("rst_ser", bus.serial_result, 0);
    @(negedge clk);
    clr_n = 1'b1;

    do_op(8'd7,   8'd3,   1'b0, 8'd10,  1'b0, 1'b0);
    do_op(8'd6,   8'd4,   1'b0, 8'd10,  1'b0, 1'b0);
    do_op(8'd200, 8'd100, 1'b0, 8'd44,  1'b1, 1'b0);
    do_op(8'd10,  8'd3,   1'b1, 8'd7,   1'b1, 1'b0);
    do_op(8'd3,   8'd10,  1'b1, 8'd249, 1'b0, 1'b0);
    do_op(8'd50,  8'd20,  1'b0, 8'd70,  1'b0, 1'b1);

    // Reset in the middle of 255+1.
    @(negedge clk);
    bus.a_in  = 8'd255;
    bus.b_in  = 8'd1;
    bus.sub   = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    clr_n = 1'b0;
    #1;
    check_val("abort_busy", bus.busy, 0);
    check_val("abort_done", bus.done, 0);
    check_val("abort_sum", bus.sum, 0);
    check_val("abort_cout", bus.cout, 0);
    check_val("abort_ser", bus.serial_result, 0);
    repeat (2) @(negedge clk);
    check_val("abort_no_done", bus.done, 0);
    clr_n = 1'b1;
    do_op(8'd255, 8'd1, 1'b0, 8'd0, 1'b1, 1'b0);

    // start held high: back-to-back ops, sum changes only with done.
    exp    = 8'd0;
    ndone  = 0;
    last   = -1;
    prev_d = 1'b0;
    @(negedge clk);
    bus.a_in  = 8'd20;
    bus.b_in  = 8'd22;
    bus.sub   = 1'b0;
    bus.start = 1'b1;
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      if (bus.done) begin
        ndone++;
        exp = (ndone == 1) ? 8'd42 : 8'd3;
        if (last >= 0) check_val("b2b_period", c - last, 10);
        last     = c;
        bus.a_in = 8'd1;
        bus.b_in = 8'd2;
      end
      check_val("b2b_sum", bus.sum, exp);
      if (prev_d) check_val("b2b_done_width", bus.done, 0);
      prev_d = bus.done;
    end
    check_val("b2b_count", ndone, 3);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
